// File: rtl/mux13_rr_sched_if.sv
// Handshake/bus bundle between mux13_rr_sched and its environment.
//   req        requester i has an item on mux input di
//   out_ready  consumer accepts the item this cycle
//   sel        mux13 select (0..12, or the idle code)
//   gnt        one-hot grant, zero when idle
//   out_valid  mux output holds a granted item
//   ack        one-hot transfer pulse back to the granted requester
//   stall_err  sticky consumer-stall flag
// master: scheduler side. slave: requesters plus consumer.
interface mux13_rr_sched_if;
  logic [12:0] req;
  logic        out_ready;
  logic [3:0]  sel;
  logic [12:0] gnt;
  logic        out_valid;
  logic [12:0] ack;
  logic        stall_err;

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output gnt,
    output out_valid,
    output ack,
    output stall_err
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  gnt,
    input  out_valid,
    input  ack,
    input  stall_err
  );
endinterface

// File: rtl/mux13_rr_sched.sv
// Round-robin scheduler sharing one mux13 datapath among 13 requesters.
// Drives the registered mux select and one-hot grant, runs valid/ready toward the single
// consumer, and pulses a one-hot ack to the requester whose item was taken.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mux13_rr_sched_if.master (req, out_ready in; sel, gnt, out_valid, ack, stall_err out)
module mux13_rr_sched #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [3:0]  IDLE_SEL = 4'hD
) (
  input  logic               clk,
  input  logic               reset,
  mux13_rr_sched_if.master   bus
);

  localparam int unsigned NREQ = 13;
  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] StallMax = CntW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q;
  logic [3:0]        sel_q;
  logic [3:0]        ptr_q;
  logic [12:0]       gnt_q;
  logic              valid_q;
  logic [CntW-1:0]   stall_cnt_q;
  logic              stall_err_q;

  logic [3:0]        nxt_ptr;
  logic [3:0]        arb_ptr;
  logic [4:0]        scan_idx;
  logic [3:0]        win_idx;
  logic              win_found;

  // Pointer that takes effect on a transfer: the winner drops to lowest priority.
  assign nxt_ptr = (sel_q == 4'(NREQ - 1)) ? 4'd0 : sel_q + 4'd1;
  // While granting, only a transfer consumes the arbiter result, so scan from nxt_ptr.
  assign arb_ptr = (state_q == StGrant) ? nxt_ptr : ptr_q;

  // First set request scanning arb_ptr, arb_ptr+1, ..., wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = 5'(arb_ptr) + 5'(k);
      if (scan_idx >= 5'(NREQ)) begin
        scan_idx = scan_idx - 5'(NREQ);
      end
      if (!win_found && bus.req[scan_idx[3:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_q       <= IDLE_SEL;
      gnt_q       <= '0;
      valid_q     <= 1'b0;
      ptr_q       <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          stall_cnt_q <= '0;
          if (win_found) begin
            state_q <= StGrant;
            sel_q   <= win_idx;
            gnt_q   <= 13'd1 << win_idx;
            valid_q <= 1'b1;
          end
        end
        StGrant: begin
          if (bus.out_ready) begin
            ptr_q       <= nxt_ptr;
            stall_cnt_q <= '0;
            if (win_found) begin
              // Back-to-back grant, no bubble.
              sel_q <= win_idx;
              gnt_q <= 13'd1 << win_idx;
            end else begin
              state_q <= StIdle;
              sel_q   <= IDLE_SEL;
              gnt_q   <= '0;
              valid_q <= 1'b0;
            end
          end else if (TIMEOUT != 0) begin
            if (stall_cnt_q != StallMax) begin
              stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            // Flag at the edge where the count reaches TIMEOUT; sticky until reset.
            if (stall_cnt_q == StallMax - 1'b1) begin
              stall_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out_valid = valid_q;
  assign bus.ack       = gnt_q & {13{valid_q & bus.out_ready}};
  assign bus.stall_err = stall_err_q;

  // A requester must hold req until its item is taken.
  req_held_a: assert property (@(posedge clk) disable iff (reset)
    (valid_q && !bus.out_ready) |-> bus.req[sel_q]);

  gnt_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));

  sel_range_a: assert property (@(posedge clk) disable iff (reset)
    (sel_q < 4'(NREQ)) || (sel_q == IDLE_SEL));

endmodule

// File: tb/tb_mux13_rr_sched.sv
module tb_mux13_rr_sched;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] req = 13'h1FFF;
  logic        out_ready = 1'b0;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b1;

  // Reference model: who holds the grant, where the scan starts, stall bookkeeping.
  bit m_valid = 1'b0;
  int m_cur = 0;
  int m_ptr = 0;
  int m_stall = 0;
  bit m_err = 1'b0;

  // Random requester backlog.
  int scnt[13];
  int last_xfer = -1;

  mux13_rr_sched_if bus_if ();

  assign bus_if.req       = req;
  assign bus_if.out_ready = out_ready;

  mux13_rr_sched #(.TIMEOUT(T), .IDLE_SEL(4'hD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [12:0] r, input int p);
    for (int k = 0; k < 13; k++) begin
      if (r[(p + k) % 13]) return (p + k) % 13;
    end
    return -1;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    int w;
    if (reset) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_stall = 0;
      m_err   = 1'b0;
    end else if (!m_valid) begin
      m_stall = 0;
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_cur   = w;
      end
    end else if (out_ready) begin
      m_stall = 0;
      m_ptr   = (m_cur + 1) % 13;
      w = pick(req, m_ptr);
      if (w >= 0) m_cur = w;
      else m_valid = 1'b0;
    end else begin
      if (m_stall < T) m_stall++;
      if (T != 0 && m_stall == T) m_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [12:0] eg;
    if (chk_en) begin
      eg = m_valid ? (13'd1 << m_cur) : 13'd0;
      check("sel", 32'(bus_if.sel), m_valid ? 32'(m_cur) : 32'hD);
      check("gnt", 32'(bus_if.gnt), 32'(eg));
      check("out_valid", 32'(bus_if.out_valid), 32'(m_valid));
      check("ack", 32'(bus_if.ack), (m_valid && out_ready) ? 32'(eg) : 32'h0);
      check("stall_err", 32'(bus_if.stall_err), 32'(m_err));
    end
  end

  task automatic step(input logic rst, input logic [12:0] r, input logic rdy);
    @(posedge clk);
    #2;
    reset     = rst;
    req       = r;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 13'h0, 1'b0);
    step(1'b0, 13'h0, 1'b0);
  endtask

  task automatic lit(input string nm, input logic [3:0] s, input logic [12:0] g,
                     input logic v, input logic [12:0] a);
    check({nm, ".sel"}, 32'(bus_if.sel), 32'(s));
    check({nm, ".gnt"}, 32'(bus_if.gnt), 32'(g));
    check({nm, ".valid"}, 32'(bus_if.out_valid), 32'(v));
    check({nm, ".ack"}, 32'(bus_if.ack), 32'(a));
  endtask

  task automatic rand_phase(input int cycles, input int arr, input int rr);
    int xi;
    logic [12:0] r;
    logic rdy;
    do_reset();
    for (int i = 0; i < 13; i++) scnt[i] = 0;
    last_xfer = -1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #2;
      if (last_xfer >= 0) scnt[last_xfer]--;
      for (int i = 0; i < 13; i++) begin
        if (scnt[i] < 3 && $urandom_range(0, 99) < arr) scnt[i]++;
      end
      rdy = ($urandom_range(0, 99) < rr);
      xi = (m_valid && rdy) ? m_cur : -1;
      for (int i = 0; i < 13; i++) begin
        r[i] = (i == xi) ? (scnt[i] >= 2) : (scnt[i] >= 1);
      end
      reset     = 1'b0;
      req       = r;
      out_ready = rdy;
      last_xfer = xi;
    end
  endtask

  initial begin
    // Reset with every request raised.
    step(1'b1, 13'h1FFF, 1'b0);
    lit("rst1", 4'hD, 13'h0, 1'b0, 13'h0);
    step(1'b1, 13'h1FFF, 1'b1);
    lit("rst2", 4'hD, 13'h0, 1'b0, 13'h0);
    check("rst.stall_err", 32'(bus_if.stall_err), 32'h0);

    // Single request, dropped in its ack cycle.
    step(1'b0, 13'h0010, 1'b1);
    lit("single.t", 4'hD, 13'h0, 1'b0, 13'h0);
    step(1'b0, 13'h0000, 1'b1);
    lit("single.t1", 4'h4, 13'h0010, 1'b1, 13'h0010);
    step(1'b0, 13'h0000, 1'b1);
    lit("single.t2", 4'hD, 13'h0, 1'b0, 13'h0);

    // Full rotation with every requester busy.
    do_reset();
    step(1'b0, 13'h1FFF, 1'b1);
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 13'h1FFF, 1'b1);
      lit("rot", 4'(k % 13), 13'd1 << (k % 13), 1'b1, 13'd1 << (k % 13));
    end

    // Backpressure on grant 7.
    do_reset();
    step(1'b0, 13'h0080, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 13'h0080, 1'b0);
      lit("bp.hold", 4'h7, 13'h0080, 1'b1, 13'h0);
    end
    step(1'b0, 13'h0000, 1'b1);
    lit("bp.go", 4'h7, 13'h0080, 1'b1, 13'h0080);
    step(1'b0, 13'h0000, 1'b1);
    lit("bp.idle", 4'hD, 13'h0, 1'b0, 13'h0);

    // Wrap from 12 to 0, then 12 alone re-granted back to back.
    do_reset();
    step(1'b0, 13'h0800, 1'b0);
    step(1'b0, 13'h1001, 1'b1);
    lit("wrap.11", 4'hB, 13'h0800, 1'b1, 13'h0800);
    step(1'b0, 13'h1001, 1'b1);
    lit("wrap.12", 4'hC, 13'h1000, 1'b1, 13'h1000);
    step(1'b0, 13'h1000, 1'b1);
    lit("wrap.0", 4'h0, 13'h0001, 1'b1, 13'h0001);
    step(1'b0, 13'h1000, 1'b1);
    lit("solo.a", 4'hC, 13'h1000, 1'b1, 13'h1000);
    step(1'b0, 13'h1000, 1'b1);
    lit("solo.b", 4'hC, 13'h1000, 1'b1, 13'h1000);
    step(1'b0, 13'h0000, 1'b1);
    lit("solo.c", 4'hC, 13'h1000, 1'b1, 13'h1000);
    step(1'b0, 13'h0000, 1'b1);
    lit("solo.idle", 4'hD, 13'h0, 1'b0, 13'h0);

    // Stall timeout, then reset mid-grant.
    do_reset();
    step(1'b0, 13'h0004, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 13'h0004, 1'b0);
      check("to.pre", 32'(bus_if.stall_err), 32'h0);
    end
    step(1'b0, 13'h0004, 1'b0);
    check("to.set", 32'(bus_if.stall_err), 32'h1);
    lit("to.held", 4'h2, 13'h0004, 1'b1, 13'h0);
    step(1'b1, 13'h0004, 1'b0);
    check("to.sticky", 32'(bus_if.stall_err), 32'h1);
    step(1'b0, 13'h0004, 1'b0);
    lit("to.rst", 4'hD, 13'h0, 1'b0, 13'h0);
    check("to.rst.err", 32'(bus_if.stall_err), 32'h0);

    // Randomized traffic against the model.
    rand_phase(1500, 10, 30);
    rand_phase(1500, 25, 70);
    rand_phase(1500, 50, 95);

    step(1'b1, 13'h0, 1'b0);
    step(1'b0, 13'h0, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
